lcd_timing_gen: RTL and testbench

- Downstream consumer of the panel-ID strap reader: takes the 16-bit ID word (3 strap bits in [2:0]) and selects the matching RGB panel timing set.
- Generates HS/VS/DE, a pixel-request strobe with X/Y coordinates for the frame source, and gates pixel data onto the LCD RGB bus.
- Runs in the pixel clock domain and also drives panel reset and backlight enable.

---
 rtl/lcd_pkg.sv | 53 +++++
 rtl/lcd_timing_gen_if.sv | 37 +++
 rtl/lcd_timing_rom.sv | 28 ++
 rtl/lcd_timing_gen.sv | 118 +++++++++++
 tb/tb_lcd_timing_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : panel ID codes, per-panel timing sets and FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam int LCD_CNT_W = 11;

    localparam logic [2:0] ID_480X272     = 3'b000;
    localparam logic [2:0] ID_800X480     = 3'b001;
    localparam logic [2:0] ID_800X480_ALT = 3'b101;
    localparam logic [2:0] ID_1024X600    = 3'b010;
    localparam logic [2:0] ID_1280X800    = 3'b100;

    typedef struct packed {
        logic [LCD_CNT_W-1:0] hsync;
        logic [LCD_CNT_W-1:0] hback;
        logic [LCD_CNT_W-1:0] hdisp;
        logic [LCD_CNT_W-1:0] htotal;
        logic [LCD_CNT_W-1:0] vsync;
        logic [LCD_CNT_W-1:0] vback;
        logic [LCD_CNT_W-1:0] vdisp;
        logic [LCD_CNT_W-1:0] vtotal;
    } lcd_timing_t;

    localparam lcd_timing_t TIM_480X272 = '{
        hsync: 11'd41,  hback: 11'd2,   hdisp: 11'd480,  htotal: 11'd525,
        vsync: 11'd10,  vback: 11'd2,   vdisp: 11'd272,  vtotal: 11'd286
    };
    localparam lcd_timing_t TIM_800X480 = '{
        hsync: 11'd128, hback: 11'd88,  hdisp: 11'd800,  htotal: 11'd1056,
        vsync: 11'd2,   vback: 11'd33,  vdisp: 11'd480,  vtotal: 11'd525
    };
    localparam lcd_timing_t TIM_1024X600 = '{
        hsync: 11'd20,  hback: 11'd140, hdisp: 11'd1024, htotal: 11'd1344,
        vsync: 11'd3,   vback: 11'd20,  vdisp: 11'd600,  vtotal: 11'd635
    };
    localparam lcd_timing_t TIM_1280X800 = '{
        hsync: 11'd10,  hback: 11'd80,  hdisp: 11'd1280, htotal: 11'd1440,
        vsync: 11'd3,   vback: 11'd10,  vdisp: 11'd800,  vtotal: 11'd823
    };

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lcd_state_e;

endpackage

`default_nettype wire

// File: rtl/lcd_timing_gen_if.sv
// ============================================================================
// lcd_timing_gen_if : frame-source request bus and LCD panel bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lcd_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic [15:0]      lcd_id;
    logic [15:0]      pixel_data;
    logic             data_req;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic [CNT_W-1:0] h_disp;
    logic [CNT_W-1:0] v_disp;
    logic             lcd_hs;
    logic             lcd_vs;
    logic             lcd_de;
    logic [15:0]      lcd_rgb;
    logic             lcd_rst;
    logic             lcd_bl;

    modport master (
        input  lcd_id, pixel_data,
        output data_req, pixel_xpos, pixel_ypos, h_disp, v_disp,
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_rst, lcd_bl
    );

    modport slave (
        output lcd_id, pixel_data,
        input  data_req, pixel_xpos, pixel_ypos, h_disp, v_disp,
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_rst, lcd_bl
    );
endinterface

`default_nettype wire

// File: rtl/lcd_timing_rom.sv
// ============================================================================
// lcd_timing_rom : strap ID to panel timing set lookup (combinational)
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_timing_rom
    import lcd_pkg::*;
(
    input  logic [2:0]  i_id,
    output lcd_timing_t o_timing
);

    always_comb begin
        o_timing = TIM_480X272;
        case (i_id)
            ID_480X272:     o_timing = TIM_480X272;
            ID_800X480,
            ID_800X480_ALT: o_timing = TIM_800X480;
            ID_1024X600:    o_timing = TIM_1024X600;
            ID_1280X800:    o_timing = TIM_1280X800;
            default:        o_timing = TIM_480X272;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// ============================================================================
// lcd_timing_gen : RGB panel HS/VS/DE generator with pixel request strobe
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int CNT_W    = LCD_CNT_W,
    parameter int WAIT_CYC = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    lcd_timing_gen_if.master bus
);

    localparam int               c_WAIT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    lcd_state_e          r_state;
    lcd_state_e          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_h_cnt;
    logic [CNT_W-1:0]    r_v_cnt;
    lcd_timing_t         r_tim;
    lcd_timing_t         w_rom;

    lcd_timing_rom u_rom (
        .i_id     (bus.lcd_id[2:0]),
        .o_timing (w_rom)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT: if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && r_wait_cnt != c_WAIT_LAST) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
        end
    end

    // Timing set is captured once per reset; later ID changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_tim <= TIM_480X272;
        else if (r_state == ST_LOAD) r_tim <= w_rom;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_state != ST_RUN) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == r_tim.htotal - c_ONE) begin
            r_h_cnt <= '0;
            if (r_v_cnt == r_tim.vtotal - c_ONE) r_v_cnt <= '0;
            else                                 r_v_cnt <= r_v_cnt + c_ONE;
        end else begin
            r_h_cnt <= r_h_cnt + c_ONE;
        end
    end

    logic             w_run;
    logic [CNT_W-1:0] w_h_start;
    logic [CNT_W-1:0] w_h_end;
    logic [CNT_W-1:0] w_req_start;
    logic [CNT_W-1:0] w_req_end;
    logic [CNT_W-1:0] w_v_start;
    logic [CNT_W-1:0] w_v_end;
    logic             w_v_win;
    logic             w_de;
    logic             w_req;

    assign w_run       = (r_state == ST_RUN);
    assign w_h_start   = r_tim.hsync + r_tim.hback;
    assign w_h_end     = w_h_start + r_tim.hdisp;
    assign w_req_start = w_h_start - c_ONE;
    assign w_req_end   = w_h_end - c_ONE;
    assign w_v_start   = r_tim.vsync + r_tim.vback;
    assign w_v_end     = w_v_start + r_tim.vdisp;

    // Requests lead DE by one clock so returned data lands in the DE cycle.
    assign w_v_win = (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);
    assign w_de    = w_run && w_v_win && (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end);
    assign w_req   = w_run && w_v_win && (r_h_cnt >= w_req_start) && (r_h_cnt < w_req_end);

    assign bus.data_req   = w_req;
    assign bus.pixel_xpos = w_req ? (r_h_cnt - w_req_start) : '0;
    assign bus.pixel_ypos = w_req ? (r_v_cnt - w_v_start) : '0;
    assign bus.h_disp     = r_tim.hdisp;
    assign bus.v_disp     = r_tim.vdisp;
    assign bus.lcd_hs     = !(w_run && (r_h_cnt < r_tim.hsync));
    assign bus.lcd_vs     = !(w_run && (r_v_cnt < r_tim.vsync));
    assign bus.lcd_de     = w_de;
    assign bus.lcd_rgb    = w_de ? bus.pixel_data : 16'h0000;
    assign bus.lcd_rst    = w_run;
    assign bus.lcd_bl     = w_run;

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
// ============================================================================
// tb_lcd_timing_gen : directed checks of panel timing, requests and pixel gating
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_timing_gen;

    localparam int WAIT_CYC = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    lcd_timing_gen_if #(.CNT_W(11)) bus ();

    lcd_timing_gen #(.CNT_W(11), .WAIT_CYC(WAIT_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame source: returns the requested coordinates one clock later
    always @(posedge clk)
        bus.pixel_data <= {bus.pixel_ypos[4:0], bus.pixel_xpos};

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input logic [15:0] id);
        bus.lcd_id = id;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Releases reset; lcd_rst must stay low WAIT_CYC+1 samples, then RUN at k=0
    task automatic wait_run(input string tag);
        rst_n = 1'b1;
        #1;
        chk({tag, "_rst_wait"}, int'(bus.lcd_rst), 0);
        for (int i = 0; i < WAIT_CYC; i++) begin
            @(negedge clk);
            chk({tag, "_rst_wait"}, int'(bus.lcd_rst), 0);
        end
        @(negedge clk);
        chk({tag, "_rst_run"}, int'(bus.lcd_rst), 1);
        chk({tag, "_bl_run"}, int'(bus.lcd_bl), 1);
    endtask

    // From k=0: counts HS-low clocks over one line and checks the line period
    task automatic measure_line(input string tag, input int hsync, input int htotal);
        int lows;
        logic prev;
        lows = 0;
        prev = 1'b0;
        for (int i = 0; i < htotal; i++) begin
            if (bus.lcd_hs == 1'b0) lows++;
            prev = bus.lcd_hs;
            @(negedge clk);
        end
        chk({tag, "_hs_low"}, lows, hsync);
        chk({tag, "_hs_before_wrap"}, int'(prev), 1);
        chk({tag, "_hs_at_wrap"}, int'(bus.lcd_hs), 0);
    endtask

    task automatic measure_vs(input string tag, input int already, input int exp);
        int lows;
        lows = already;
        for (int i = 0; i < exp + 2000 && bus.lcd_vs == 1'b0; i++) begin
            lows++;
            @(negedge clk);
        end
        chk({tag, "_vs_low_clks"}, lows, exp);
    endtask

    // Runs from RUN cycle k0 to the first DE; stops on that sample
    task automatic first_active(input string tag, input int k0, input int exp_req_k, input int exp_de_k);
        int k, rk, rx, ry;
        bit seen, found;
        k = k0; rk = -1; rx = -1; ry = -1; seen = 0; found = 0;
        for (int i = 0; i < exp_de_k + 100; i++) begin
            if (bus.data_req && !seen) begin
                seen = 1; rk = k; rx = int'(bus.pixel_xpos); ry = int'(bus.pixel_ypos);
            end
            if (bus.lcd_de) begin
                found = 1;
                break;
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_de_found"}, int'(found), 1);
        chk({tag, "_first_de_k"}, k, exp_de_k);
        chk({tag, "_first_req_k"}, rk, exp_req_k);
        chk({tag, "_first_req_x"}, rx, 0);
        chk({tag, "_first_req_y"}, ry, 0);
    endtask

    initial begin
        int de_n, req_n;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.lcd_id = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hs", int'(bus.lcd_hs), 1);
        chk("rst_vs", int'(bus.lcd_vs), 1);
        chk("rst_de", int'(bus.lcd_de), 0);
        chk("rst_req", int'(bus.data_req), 0);
        chk("rst_xpos", int'(bus.pixel_xpos), 0);
        chk("rst_ypos", int'(bus.pixel_ypos), 0);
        chk("rst_rgb", int'(bus.lcd_rgb), 0);
        chk("rst_lcd_rst", int'(bus.lcd_rst), 0);
        chk("rst_bl", int'(bus.lcd_bl), 0);
        chk("rst_h_disp", int'(bus.h_disp), 480);
        chk("rst_v_disp", int'(bus.v_disp), 272);

        // ID 0: 480x272
        wait_run("id0");
        chk("id0_h_disp", int'(bus.h_disp), 480);
        chk("id0_v_disp", int'(bus.v_disp), 272);
        measure_line("id0", 41, 525);
        measure_vs("id0", 525, 10 * 525);

        // ID 1: 800x480, first active pixel and a full line of pixel data
        apply_reset(16'h0001);
        wait_run("id1");
        chk("id1_h_disp", int'(bus.h_disp), 800);
        chk("id1_v_disp", int'(bus.v_disp), 480);
        first_active("id1", 0, 35 * 1056 + 215, 35 * 1056 + 216);
        de_n = 0;
        req_n = 1;
        for (int i = 0; i < 900; i++) begin
            if (bus.lcd_de) begin
                chk("id1_rgb_de", int'(bus.lcd_rgb), de_n);
                de_n++;
            end else begin
                chk("id1_rgb_idle", int'(bus.lcd_rgb), 0);
            end
            if (bus.data_req) begin
                chk("id1_req_x", int'(bus.pixel_xpos), req_n);
                chk("id1_req_y", int'(bus.pixel_ypos), 0);
                req_n++;
            end
            @(negedge clk);
        end
        chk("id1_de_per_line", de_n, 800);
        chk("id1_req_per_line", req_n, 800);

        // ID 5 aliases ID 1
        apply_reset(16'h0005);
        wait_run("id5");
        chk("id5_h_disp", int'(bus.h_disp), 800);
        chk("id5_v_disp", int'(bus.v_disp), 480);
        measure_line("id5", 128, 1056);
        measure_vs("id5", 1056, 2 * 1056);

        // ID 6 undefined: falls back to 480x272
        apply_reset(16'h0006);
        wait_run("id6");
        chk("id6_h_disp", int'(bus.h_disp), 480);
        chk("id6_v_disp", int'(bus.v_disp), 272);
        measure_line("id6", 41, 525);

        // ID 4: 1280x800
        apply_reset(16'h0004);
        wait_run("id4");
        chk("id4_h_disp", int'(bus.h_disp), 1280);
        chk("id4_v_disp", int'(bus.v_disp), 800);
        measure_line("id4", 10, 1440);
        first_active("id4", 1440, 13 * 1440 + 89, 13 * 1440 + 90);

        // Mid-line asynchronous reset while HS is low, new ID sampled after WAIT
        apply_reset(16'h0001);
        wait_run("mid");
        repeat (50) @(negedge clk);
        chk("mid_hs_before", int'(bus.lcd_hs), 0);
        bus.lcd_id = 16'h0002;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_hs", int'(bus.lcd_hs), 1);
        chk("mid_async_rst", int'(bus.lcd_rst), 0);
        chk("mid_async_bl", int'(bus.lcd_bl), 0);
        chk("mid_async_h_disp", int'(bus.h_disp), 480);
        repeat (2) @(negedge clk);
        wait_run("id2");
        chk("id2_h_disp", int'(bus.h_disp), 1024);
        chk("id2_v_disp", int'(bus.v_disp), 600);
        measure_line("id2", 20, 1344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
